// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the SRAM data-port arbiter.
package sram_arb_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  localparam int STARVE_LIMIT = 4;
  localparam int RSP_DEPTH    = 2;

endpackage

// File: rtl/sram_arb_rsp_fifo.sv
// In-order tracker of granted master IDs awaiting a read/write response.
module sram_arb_rsp_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = sram_arb_pkg::RSP_DEPTH
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  master_id_e push_id_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output master_id_e head_id_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  master_id_e    ids_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_en, pop_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign full_o    = (cnt_q == CNT_FULL);
  assign empty_o   = (cnt_q == '0);
  assign head_id_o = ids_q[rd_ptr_q];

  // A push into a full tracker is only accepted when the head leaves in the same cycle.
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) ids_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/sram_d_arbiter.sv
// Two-master OBI arbiter in front of the SRAM data port with m1 starvation guard.
module sram_d_arbiter
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = sram_arb_pkg::STARVE_LIMIT,
  parameter int RSP_DEPTH    = sram_arb_pkg::RSP_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  input  logic        s_gnt_i,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  output logic        protocol_err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;
  logic          perr_q, perr_d;
  master_id_e    winner, head_id;
  logic          win_req, handshake, pop, full, empty;

  assign winner  = (m1_req_i && (!m0_req_i || starve_q == LIMIT)) ? M1 : M0;
  assign win_req = (winner == M1) ? m1_req_i : m0_req_i;

  // Outputs are gated by rst_ni so they drop immediately on an asynchronous reset.
  assign s_req_o   = rst_ni && win_req && (!full || s_rvalid_i);
  assign handshake = s_req_o && s_gnt_i;
  assign m0_gnt_o  = handshake && (winner == M0);
  assign m1_gnt_o  = handshake && (winner == M1);

  assign s_addr_o  = (winner == M1) ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = (winner == M1) ? m1_we_i    : m0_we_i;
  assign s_be_o    = (winner == M1) ? m1_be_i    : m0_be_i;
  assign s_wdata_o = (winner == M1) ? m1_wdata_i : m0_wdata_i;

  assign pop         = rst_ni && s_rvalid_i && !empty;
  assign m0_rvalid_o = pop && (head_id == M0);
  assign m1_rvalid_o = pop && (head_id == M1);
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

  assign protocol_err_o = perr_q;

  always_comb begin
    starve_d = starve_q;
    perr_d   = perr_q | (s_rvalid_i & empty);
    if (!m1_req_i || m1_gnt_o) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      perr_q   <= perr_d;
    end
  end

  sram_arb_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (handshake),
    .push_id_i(winner),
    .pop_i    (pop),
    .full_o   (full),
    .empty_o  (empty),
    .head_id_o(head_id)
  );

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Directed bench for sram_d_arbiter: arbitration, starvation, tracker and reset.
module tb_sram_d_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_be_i;
  logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_be_i;
  logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i, protocol_err_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_d_arbiter #(.STARVE_LIMIT(4), .RSP_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .protocol_err_o(protocol_err_o)
  );

  task automatic idle_inputs();
    m0_req_i = 0; m0_addr_i = '0; m0_we_i = 0; m0_be_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_addr_i = '0; m1_we_i = 0; m1_be_i = '0; m1_wdata_i = '0;
    s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0;
  endtask

  // Advance to just after the next rising edge; caller then drives and checks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    idle_inputs();
    step();
    step();
    rst_ni = 1;
    step();
  endtask

  task automatic test_reset();
    rst_ni = 0;
    idle_inputs();
    m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1; s_rvalid_i = 1; s_rdata_i = 32'hA5A5_A5A5;
    step();
    #1;
    n_tests++; if (m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset m0_gnt got %0b want 0", m0_gnt_o); end
    n_tests++; if (m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset m1_gnt got %0b want 0", m1_gnt_o); end
    n_tests++; if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL reset s_req got %0b want 0", s_req_o); end
    n_tests++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL reset rvalid got %b want 00", {m0_rvalid_o, m1_rvalid_o}); end
    n_tests++; if ((m0_rdata_o | m1_rdata_o) !== 32'h0) begin n_fail++; $display("FAIL reset rdata got %h/%h want 0", m0_rdata_o, m1_rdata_o); end
    n_tests++; if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL reset perr got %0b want 0", protocol_err_o); end
    idle_inputs();
    step();
    rst_ni = 1;
    step();
  endtask

  task automatic test_m0_alone();
    // Write 0xDEADBEEF to 0x8000_0010.
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h8000_0010; m0_be_i = 4'hF; m0_wdata_i = 32'hDEAD_BEEF;
    s_gnt_i = 1;
    #1;
    n_tests++; if (m0_gnt_o !== 1'b1) begin n_fail++; $display("FAIL m0_alone wr gnt got %0b want 1", m0_gnt_o); end
    n_tests++; if ({s_req_o, s_we_o, s_be_o} !== 6'b1_1_1111) begin n_fail++; $display("FAIL m0_alone wr ctrl got %b want 111111", {s_req_o, s_we_o, s_be_o}); end
    n_tests++; if (s_addr_o !== 32'h8000_0010) begin n_fail++; $display("FAIL m0_alone wr addr got %h want 80000010", s_addr_o); end
    n_tests++; if (s_wdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL m0_alone wr wdata got %h want deadbeef", s_wdata_o); end
    n_tests++; if (m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL m0_alone wr m1_gnt got %0b want 0", m1_gnt_o); end
    step();
    // Read issued while write response returns.
    m0_we_i = 0; m0_wdata_i = '0; s_rvalid_i = 1; s_rdata_i = '0;
    #1;
    n_tests++; if (m0_gnt_o !== 1'b1) begin n_fail++; $display("FAIL m0_alone rd gnt got %0b want 1", m0_gnt_o); end
    n_tests++; if (s_we_o !== 1'b0) begin n_fail++; $display("FAIL m0_alone rd we got %0b want 0", s_we_o); end
    n_tests++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10) begin n_fail++; $display("FAIL m0_alone wr rsp rvalid got %b want 10", {m0_rvalid_o, m1_rvalid_o}); end
    step();
    m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (m0_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL m0_alone rd rvalid got %0b want 1", m0_rvalid_o); end
    n_tests++; if (m0_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL m0_alone rd rdata got %h want deadbeef", m0_rdata_o); end
    n_tests++; if ({m1_rvalid_o, m1_gnt_o, m1_rdata_o} !== 34'h0) begin n_fail++; $display("FAIL m0_alone m1 outs got %b/%b/%h want 0", m1_rvalid_o, m1_gnt_o, m1_rdata_o); end
    step();
    idle_inputs();
    #1;
    n_tests++; if (m0_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL m0_alone idle rvalid got %0b want 0", m0_rvalid_o); end
    n_tests++; if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL m0_alone perr got %0b want 0", protocol_err_o); end
  endtask

  task automatic test_starvation();
    logic exp_m1, exp_m1_rsp;
    m0_req_i = 1; m0_addr_i = 32'h0000_0100;
    m1_req_i = 1; m1_addr_i = 32'h0000_0200;
    s_gnt_i = 1;
    for (int i = 0; i < 10; i++) begin
      // Counter reaches 4 on every fifth cycle, so grants go m0,m0,m0,m0,m1,...
      exp_m1     = ((i % 5) == 4);
      exp_m1_rsp = (i > 0) && (((i - 1) % 5) == 4);
      s_rvalid_i = (i > 0);
      s_rdata_i  = 32'h100 + i;
      #1;
      n_tests++; if ({m0_gnt_o, m1_gnt_o} !== {~exp_m1, exp_m1}) begin n_fail++; $display("FAIL starve gnt[%0d] got %b want %b", i, {m0_gnt_o, m1_gnt_o}, {~exp_m1, exp_m1}); end
      n_tests++; if (s_addr_o !== (exp_m1 ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL starve addr[%0d] got %h", i, s_addr_o); end
      if (i > 0) begin
        n_tests++; if ({m0_rvalid_o, m1_rvalid_o} !== {~exp_m1_rsp, exp_m1_rsp}) begin n_fail++; $display("FAIL starve rvalid[%0d] got %b want %b", i, {m0_rvalid_o, m1_rvalid_o}, {~exp_m1_rsp, exp_m1_rsp}); end
        n_tests++; if ((exp_m1_rsp ? m1_rdata_o : m0_rdata_o) !== 32'h100 + i) begin n_fail++; $display("FAIL starve rdata[%0d] got %h want %h", i, exp_m1_rsp ? m1_rdata_o : m0_rdata_o, 32'h100 + i); end
      end
      step();
    end
    idle_inputs();
    s_rvalid_i = 1; s_rdata_i = 32'h10A;
    #1;
    n_tests++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01) begin n_fail++; $display("FAIL starve drain rvalid got %b want 01", {m0_rvalid_o, m1_rvalid_o}); end
    step();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [3];
    rd[0] = 32'h1111_0000; rd[1] = 32'h2222_0000; rd[2] = 32'h3333_0000;
    s_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      m0_req_i   = (i == 0) || (i == 2);
      m1_req_i   = (i == 1);
      s_rvalid_i = (i > 0);
      s_rdata_i  = (i > 0) ? rd[i-1] : '0;
      #1;
      if (i < 3) begin
        n_tests++; if ({m0_gnt_o, m1_gnt_o} !== {m0_req_i, m1_req_i}) begin n_fail++; $display("FAIL b2b gnt[%0d] got %b want %b", i, {m0_gnt_o, m1_gnt_o}, {m0_req_i, m1_req_i}); end
      end
      if (i == 1 || i == 3) begin
        n_tests++; if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== {2'b10, rd[i-1], 32'h0}) begin n_fail++; $display("FAIL b2b rsp[%0d] got %b %h %h want m0 %h", i, {m0_rvalid_o, m1_rvalid_o}, m0_rdata_o, m1_rdata_o, rd[i-1]); end
      end
      if (i == 2) begin
        n_tests++; if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== {2'b01, 32'h0, rd[1]}) begin n_fail++; $display("FAIL b2b rsp[2] got %b %h %h want m1 %h", {m0_rvalid_o, m1_rvalid_o}, m0_rdata_o, m1_rdata_o, rd[1]); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_tracker_full();
    logic exp [6];
    // Two grants fill the tracker; stall; pop in cycle 4 admits one push; stall again.
    exp[0] = 1; exp[1] = 1; exp[2] = 0; exp[3] = 0; exp[4] = 1; exp[5] = 0;
    m0_req_i = 1; s_gnt_i = 1;
    for (int i = 0; i < 6; i++) begin
      s_rvalid_i = (i == 4);
      s_rdata_i  = 32'h0000_4444;
      #1;
      n_tests++; if ({s_req_o, m0_gnt_o} !== {exp[i], exp[i]}) begin n_fail++; $display("FAIL full req/gnt[%0d] got %b want %b", i, {s_req_o, m0_gnt_o}, {exp[i], exp[i]}); end
      if (i == 4) begin
        n_tests++; if (m0_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL full pop rvalid got %0b want 1", m0_rvalid_o); end
      end
      step();
    end
    m0_req_i = 0; s_gnt_i = 0;
    for (int i = 0; i < 2; i++) begin
      s_rvalid_i = 1;
      #1;
      n_tests++; if (m0_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL full drain[%0d] rvalid got %0b want 1", i, m0_rvalid_o); end
      step();
    end
    idle_inputs();
    #1;
    n_tests++; if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL full perr got %0b want 0", protocol_err_o); end
  endtask

  task automatic test_protocol_err();
    s_rvalid_i = 1; s_rdata_i = 32'hBAD0_BAD0;
    #1;
    n_tests++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL perr stray rvalid got %b want 00", {m0_rvalid_o, m1_rvalid_o}); end
    n_tests++; if ((m0_rdata_o | m1_rdata_o) !== 32'h0) begin n_fail++; $display("FAIL perr stray rdata got %h/%h want 0", m0_rdata_o, m1_rdata_o); end
    step();
    idle_inputs();
    #1;
    n_tests++; if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL perr set got %0b want 1", protocol_err_o); end
    step(); step(); step();
    n_tests++; if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL perr sticky got %0b want 1", protocol_err_o); end
    rst_ni = 0;
    #1;
    n_tests++; if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL perr clear got %0b want 0", protocol_err_o); end
    step();
    rst_ni = 1;
    step();
  endtask

  task automatic test_reset_mid();
    m0_req_i = 1; s_gnt_i = 1;
    #1;
    n_tests++; if (m0_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rstmid gnt got %0b want 1", m0_gnt_o); end
    step();
    m0_req_i = 0; m1_req_i = 1;
    #2;
    rst_ni = 0;
    s_rvalid_i = 1; s_rdata_i = 32'h5555_AAAA;
    #1;
    n_tests++; if ({s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 5'b0) begin n_fail++; $display("FAIL rstmid outs got %b want 00000", {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o}); end
    n_tests++; if ((m0_rdata_o | m1_rdata_o) !== 32'h0) begin n_fail++; $display("FAIL rstmid rdata got %h/%h want 0", m0_rdata_o, m1_rdata_o); end
    step();
    idle_inputs();
    rst_ni = 1;
    step();
    n_tests++; if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL rstmid perr after release got %0b want 0", protocol_err_o); end
    // Late response for the discarded transaction.
    s_rvalid_i = 1; s_rdata_i = 32'h5555_AAAA;
    #1;
    n_tests++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL rstmid late rvalid got %b want 00", {m0_rvalid_o, m1_rvalid_o}); end
    step();
    idle_inputs();
    #1;
    n_tests++; if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL rstmid late perr got %0b want 1", protocol_err_o); end
  endtask

  initial begin
    rst_ni = 0;
    idle_inputs();
    test_reset();
    test_m0_alone();
    test_starvation();
    test_back_to_back();
    test_tracker_full();
    test_protocol_err();
    test_reset_mid();
    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_d_arbiter.md
SRAM_D_ARBITER -- requirements
Module: sram_d_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles m1 may wait with m1_req_i high and no grant before it is forced to win.
REQ-002 SHALL have parameter RSP_DEPTH, default 2, meaning the maximum number of granted transactions whose response is still outstanding.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 m0_req_i/m0_gnt_o/m0_addr_i/m0_we_i/m0_be_i/m0_wdata_i/m0_rvalid_o/m0_rdata_o  in/out/in/in/in/in/out/out  1/1/32/1/4/32/1/32  OBI subordinate port for master 0 (core data).
REQ-006 m1_* signals  same directions and widths as m0_*  OBI subordinate port for master 1 (DMA/debug).
REQ-007 s_req_o/s_gnt_i/s_addr_o/s_we_o/s_be_o/s_wdata_o/s_rvalid_i/s_rdata_i  out/in/out/out/out/out/in/in  1/1/32/1/4/32/1/32  OBI manager port to the SRAM wrapper data port.
REQ-008 protocol_err_o  out  1  sticky flag: a response arrived with no transaction outstanding.

Function
REQ-009 Default priority: m0 wins when both request, unless the starvation rule (REQ-011) is active.
REQ-010 Starvation counter: increments each cycle m1_req_i=1 and m1_gnt_o=0; saturates at STARVE_LIMIT; clears when m1 is granted or m1_req_i=0.
REQ-011 When the counter equals STARVE_LIMIT, m1 wins arbitration in that cycle over m0.
REQ-012 s_req_o = (winner's req) AND response tracker not full, OR full with s_rvalid_i=1 in the same cycle.
REQ-013 s_addr_o/s_we_o/s_be_o/s_wdata_o are taken combinationally from the winner; m0 payload is driven when no master requests.
REQ-014 Winner's gnt_o = s_gnt_i AND s_req_o; loser's gnt_o = 0; no request is dropped, and a loser holds its request until granted.
REQ-015 Grant latency: zero cycles when downstream grants combinationally and the tracker has room.
REQ-016 Each handshake (s_req_o AND s_gnt_i) pushes the winner ID into an in-order response tracker of RSP_DEPTH entries.
REQ-017 Each s_rvalid_i pops the tracker head and asserts that master's rvalid_o in the same cycle, with rdata_o = s_rdata_i.
REQ-018 The non-addressed master's rvalid_o = 0 and rdata_o = 0.
REQ-019 Simultaneous push and pop SHALL be legal at any fill level, including full; occupancy is then unchanged.
REQ-020 s_rvalid_i with the tracker empty: no master rvalid, tracker unchanged, protocol_err_o set until reset.
REQ-021 Tracker pointers wrap modulo RSP_DEPTH; the occupancy counter is $clog2(RSP_DEPTH+1) bits wide.

Reset
REQ-022 On rst_ni low (asynchronous), the tracker SHALL empty, the starvation counter = 0, and protocol_err_o = 0.
REQ-023 During reset, all gnt_o, rvalid_o, rdata_o, s_req_o = 0.
REQ-024 Reset asserted mid-transaction SHALL discard outstanding IDs; a response arriving after reset release sets protocol_err_o.

Structure
REQ-025 Package sram_arb_pkg SHALL hold typedef master_id_e (M0=0, M1=1) and the default constants STARVE_LIMIT and RSP_DEPTH.
REQ-026 The response tracker SHALL be a sub-module sram_arb_rsp_fifo: push, pop, full, empty, head ID, async active-low reset.
REQ-027 The top level SHALL contain only arbitration, the starvation counter, muxing and the error flag.

Verification
REQ-028 m0 alone, addr 0x8000_0010 write then read, s_gnt_i tied 1, rvalid 1 cycle later -> m0_gnt_o same cycle, m0_rvalid_o next cycle, m0_rdata_o = written data, m1 outputs 0.
REQ-029 m0 and m1 both request continuously, limit 4 -> m1 wait counter reaches 4, m1 granted in that cycle, then m0 resumes; pattern repeats every 5 grants.
REQ-030 Back-to-back alternating grants m0, m1, m0 with 1-cycle response latency -> rvalid/rdata routed to m0, m1, m0 in order.
REQ-031 s_gnt_i held 1 and s_rvalid_i held 0 -> exactly 2 grants, then s_req_o = 0; one s_rvalid_i pulse frees a slot, and the push in the pop cycle is accepted.
REQ-032 s_rvalid_i pulsed with tracker empty -> no rvalid_o, protocol_err_o = 1 until rst_ni is low.
REQ-033 rst_ni asserted with 1 transaction outstanding -> all outputs 0 immediately; after release the tracker is empty and protocol_err_o = 0.
